// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment definitions for the display blocks.
// Segment bit order (active-high): [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp
package seg_pkg;

  // One packed-BCD digit.
  typedef logic [3:0] digit_t;

  // Bit positions within an 8-bit segment word.
  localparam int SEG_BIT_A  = 7;
  localparam int SEG_BIT_B  = 6;
  localparam int SEG_BIT_C  = 5;
  localparam int SEG_BIT_D  = 4;
  localparam int SEG_BIT_E  = 3;
  localparam int SEG_BIT_F  = 2;
  localparam int SEG_BIT_G  = 1;
  localparam int SEG_BIT_DP = 0;

  // Glyphs for the decimal digits, a dash for non-BCD input, and all-off.
  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'h02;
  localparam logic [7:0] SEG_OFF  = 8'h00;

endpackage

// File: rtl/seg_bcd_decode.sv
// seg_bcd_decode: combinational BCD nibble to 7-segment glyph.
// Non-BCD codes (A-F) show a dash; the decimal point is never lit here.
module seg_bcd_decode
  import seg_pkg::*;
(
  input  digit_t     digit,
  output logic [7:0] seg
);

  // Lookup of the glyph for one nibble.
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexes DIGITS packed-BCD digits onto one segment bus.
// A prescaler produces one tick per digit slot; the BCD word is captured into a
// shadow register only at frame boundaries (or on enable) so a frame is coherent.
// Optional: define SEG_LZ_BLANK_EN to blank leading-zero digits (ones digit always shown).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [4*DIGITS-1:0]  shadow;
  logic                 armed;     // high once the first enabled cycle has loaded the shadow
  logic                 tick;
  logic                 wrap;
  digit_t               cur_digit;
  logic [7:0]           dec_seg;
  logic [7:0]           disp_seg;

  // Slot end and frame end; en gates both so a falling en suppresses the pulse.
  assign tick = en && (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // Prescaler, digit index and shadow capture; en low clears the scan but keeps the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      armed  <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      idx   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      cnt   <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      if (!armed || wrap) shadow <= bcd;
    end
  end

  // Pick the nibble for the current index out of the shadow word.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) cur_digit = shadow[4*i +: 4];
    end
  end

  seg_bcd_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic blank;

  // Blank digit i>0 when it and every higher nibble are zero.
  always_comb begin
    blank = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (IW'(i) == idx) begin
        blank = 1'b1;
        for (int j = i; j < DIGITS; j++) begin
          if (shadow[4*j +: 4] != 4'd0) blank = 1'b0;
        end
      end
    end
    disp_seg = blank ? SEG_OFF : dec_seg;
  end
`else
  // Every digit is decoded, including leading zeros.
  always_comb begin
    disp_seg = dec_seg;
  end
`endif

  // Registered drive; outputs stay dark until the cycle after the shadow is first loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en && armed) begin
        seg <= disp_seg;
        an  <= DIGITS'(1) << idx;
      end else begin
        seg <= SEG_OFF;
        an  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of seg_scan_driver with DIGITS=3, SCAN_DIV=4.
module tb_seg_scan_driver;

  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] LZ = 8'h00;
`else
  localparam logic [7:0] LZ = 8'hFC;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [4*DIGITS-1:0] bcd;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_seen = 0;

  seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bcd        (bcd),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  // Clock: posedges at 5, 15, 25 ...; sampling and driving happen on negedges.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] an_e, input logic [7:0] seg_e,
                         input logic fd_e);
    chk({tag, ".an"}, 8'(an), 8'(an_e));
    chk({tag, ".seg"}, seg, seg_e);
    chk({tag, ".fd"}, 8'(frame_done), 8'(fd_e));
  endtask

  // Advance n negedges, counting frame_done pulses seen along the way.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_seen++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bcd = '0;
    step(2);
    chk_out("reset", 3'b000, 8'h00, 1'b0);
    rst = 1'b0;
    step(1);
    chk_out("idle_en0", 3'b000, 8'h00, 1'b0);

    // Normal scan of 123; E counts posedges since en rose.
    en = 1'b1; bcd = 12'h123;
    step(1); chk_out("e1_dark", 3'b000, 8'h00, 1'b0);
    step(1); chk_out("e2_d0", 3'b001, 8'hF2, 1'b0);
    step(2); chk_out("e4_d0", 3'b001, 8'hF2, 1'b0);
    step(1); chk_out("e5_d1", 3'b010, 8'hDA, 1'b0);
    step(4); chk_out("e9_d2", 3'b100, 8'h60, 1'b0);
    step(3); chk_out("e12_fd", 3'b100, 8'h60, 1'b1);
    step(1); chk_out("e13_d0", 3'b001, 8'hF2, 1'b0);

    // Frame coherence: change bcd in the middle of digit 1's slot.
    step(5); chk_out("e18_d1", 3'b010, 8'hDA, 1'b0);
    bcd = 12'h456;
    step(1); chk_out("e19_old1", 3'b010, 8'hDA, 1'b0);
    step(2); chk_out("e21_old2", 3'b100, 8'h60, 1'b0);
    step(3); chk_out("e24_fd", 3'b100, 8'h60, 1'b1);
    step(1); chk_out("e25_new6", 3'b001, 8'hBE, 1'b0);
    step(4); chk_out("e29_new5", 3'b010, 8'hB6, 1'b0);
    step(4); chk_out("e33_new4", 3'b100, 8'h66, 1'b0);

    // Invalid nibble, loaded at the next frame boundary.
    bcd = 12'h1A3;
    step(3); chk_out("e36_fd", 3'b100, 8'h66, 1'b1);
    chk("fd_count3", 8'(fd_seen), 8'd3);
    step(1); chk_out("e37_3", 3'b001, 8'hF2, 1'b0);
    step(4); chk_out("e41_dash", 3'b010, 8'h02, 1'b0);
    step(4); chk_out("e45_1", 3'b100, 8'h60, 1'b0);

    // en falls right before the wrap tick: blank outputs, no frame_done.
    step(2); chk_out("e47_d2", 3'b100, 8'h60, 1'b0);
    en = 1'b0;
    step(1); chk_out("en0_clear", 3'b000, 8'h00, 1'b0);
    chk("fd_count_en0", 8'(fd_seen), 8'd3);
    bcd = 12'h789;
    step(3); chk_out("en0_hold", 3'b000, 8'h00, 1'b0);

    // en re-raised: digit 0 on the second cycle with the fresh value.
    en = 1'b1;
    step(1); chk_out("re_e1", 3'b000, 8'h00, 1'b0);
    step(1); chk_out("re_e2_9", 3'b001, 8'hF6, 1'b0);
    step(3); chk_out("re_e5_8", 3'b010, 8'hFE, 1'b0);

    // Async reset between edges: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 3'b000, 8'h00, 1'b0);
    step(2); chk_out("rst_hold", 3'b000, 8'h00, 1'b0);
    rst = 1'b0; bcd = 12'h007;

    // Leading zeros after reset release.
    step(1); chk_out("lz_e1", 3'b000, 8'h00, 1'b0);
    step(1); chk_out("lz_e2_7", 3'b001, 8'hE0, 1'b0);
    step(3); chk_out("lz_e5_d1", 3'b010, LZ, 1'b0);
    step(4); chk_out("lz_e9_d2", 3'b100, LZ, 1'b0);
    bcd = 12'h000;
    step(3); chk_out("lz_e12_fd", 3'b100, LZ, 1'b1);
    step(1); chk_out("z_e13_d0", 3'b001, 8'hFC, 1'b0);
    step(4); chk_out("z_e17_d1", 3'b010, LZ, 1'b0);
    step(4); chk_out("z_e21_d2", 3'b100, LZ, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
